// File: rtl/mnist_dlayer2_seq_pkg.sv
// Shared constants, FSM encoding and result post-processing for the layer-2 dense-node sequencer.
// Optional feature macro: MNIST_DL2_RELU_EN (sign-bit ReLU on results).
package mnist_dlayer2_seq_pkg;

    localparam int unsigned NIN      = 20;
    localparam int unsigned NOUT     = 10;
    localparam int unsigned NODE_LAT = 3;
    localparam int unsigned IDXW     = 4;
    localparam int unsigned WORDW    = 32;
    localparam int unsigned VECW     = NIN * WORDW;
    localparam int unsigned ECW      = 5;
    localparam int unsigned LATW     = 2;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    function automatic logic [WORDW-1:0] post_act(input logic [WORDW-1:0] c);
`ifdef MNIST_DL2_RELU_EN
        post_act = c[WORDW-1] ? {WORDW{1'b0}} : c;
`else
        post_act = c;
`endif
    endfunction

endpackage

// File: rtl/mnist_dlayer2_seq_packer.sv
// Serial-to-640-bit activation packer; the packed vector only changes when a full vector completes.
module mnist_dlayer2_seq_packer
    import mnist_dlayer2_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             act_valid,
    input  logic             act_ready,
    input  logic [WORDW-1:0] act_data,
    output logic             vec_done,
    output logic [VECW-1:0]  vec
);

    logic [ECW-1:0]   elem_cnt_q, elem_cnt_d;
    logic [WORDW-1:0] stage_q [NIN-1];
    logic [WORDW-1:0] stage_d [NIN-1];
    logic [VECW-1:0]  vec_q, vec_d;
    logic             accept_s;

    assign accept_s = act_valid & act_ready;
    assign vec_done = accept_s & (elem_cnt_q == ECW'(NIN - 1));
    assign vec      = vec_q;

    // Next-state: stage words 0..NIN-2, publish the whole vector on the last word.
    always_comb begin
        elem_cnt_d = elem_cnt_q;
        stage_d    = stage_q;
        vec_d      = vec_q;
        if (vec_done) begin
            elem_cnt_d = {ECW{1'b0}};
            for (int i = 0; i < NIN - 1; i++) begin
                vec_d[i*WORDW +: WORDW] = stage_q[i];
            end
            vec_d[VECW-1 -: WORDW] = act_data;
        end else if (accept_s) begin
            elem_cnt_d          = elem_cnt_q + ECW'(1);
            stage_d[elem_cnt_q] = act_data;
        end else begin
            elem_cnt_d = elem_cnt_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt_q <= {ECW{1'b0}};
            stage_q    <= '{default: {WORDW{1'b0}}};
            vec_q      <= {VECW{1'b0}};
        end else begin
            elem_cnt_q <= elem_cnt_d;
            stage_q    <= stage_d;
            vec_q      <= vec_d;
        end
    end

endmodule

// File: rtl/mnist_dlayer2_seq.sv
// Layer-2 dense-node sequencer: packs activations, fetches weight/bias per neuron, returns results.
// Optional feature macro: MNIST_DL2_RELU_EN (sign-bit ReLU on res_data, no added latency).
module mnist_dlayer2_seq
    import mnist_dlayer2_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             act_valid,
    output logic             act_ready,
    input  logic [WORDW-1:0] act_data,
    output logic             w_rd,
    output logic [IDXW-1:0]  w_addr,
    input  logic [VECW-1:0]  w_rdata,
    input  logic [WORDW-1:0] b_rdata,
    output logic [VECW-1:0]  node_a,
    output logic [VECW-1:0]  node_b,
    output logic [WORDW-1:0] node_bias,
    input  logic [WORDW-1:0] node_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WORDW-1:0] res_data,
    output logic [IDXW-1:0]  res_idx,
    output logic             res_last
);

    state_t           state_q, state_d;
    logic [IDXW-1:0]  nidx_q, nidx_d;
    logic [LATW-1:0]  lat_cnt_q, lat_cnt_d;
    logic             act_ready_q, act_ready_d;
    logic             w_rd_q, w_rd_d;
    logic [VECW-1:0]  node_b_q, node_b_d;
    logic [WORDW-1:0] node_bias_q, node_bias_d;
    logic             res_valid_q, res_valid_d;
    logic [WORDW-1:0] res_data_q, res_data_d;
    logic             res_last_q, res_last_d;
    logic             vec_done_s;

    mnist_dlayer2_seq_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .act_valid (act_valid),
        .act_ready (act_ready_q),
        .act_data  (act_data),
        .vec_done  (vec_done_s),
        .vec       (node_a)
    );

    assign act_ready = act_ready_q;
    assign w_rd      = w_rd_q;
    assign w_addr    = nidx_q;
    assign node_b    = node_b_q;
    assign node_bias = node_bias_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = nidx_q;
    assign res_last  = res_last_q;

    // Sequencer next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        nidx_d      = nidx_q;
        lat_cnt_d   = lat_cnt_q;
        act_ready_d = act_ready_q;
        w_rd_d      = 1'b0;
        node_b_d    = node_b_q;
        node_bias_d = node_bias_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_last_d  = res_last_q;
        case (state_q)
            ST_LOAD: begin
                act_ready_d = 1'b1;
                if (vec_done_s) begin
                    state_d     = ST_FETCH;
                    nidx_d      = {IDXW{1'b0}};
                    act_ready_d = 1'b0;
                    w_rd_d      = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FETCH: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                node_b_d    = w_rdata;
                node_bias_d = b_rdata;
                lat_cnt_d   = {LATW{1'b0}};
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // node_c is valid NODE_LAT cycles after CAPT; sample it on the following edge.
                if (lat_cnt_q == LATW'(NODE_LAT)) begin
                    res_data_d  = post_act(node_c);
                    res_valid_d = 1'b1;
                    res_last_d  = (nidx_q == IDXW'(NOUT - 1));
                    state_d     = ST_OUT;
                end else begin
                    lat_cnt_d = lat_cnt_q + LATW'(1);
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                    if (nidx_q == IDXW'(NOUT - 1)) begin
                        nidx_d      = {IDXW{1'b0}};
                        act_ready_d = 1'b1;
                        state_d     = ST_LOAD;
                    end else begin
                        nidx_d  = nidx_q + IDXW'(1);
                        w_rd_d  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d     = ST_LOAD;
                nidx_d      = {IDXW{1'b0}};
                act_ready_d = 1'b0;
                res_valid_d = 1'b0;
                res_last_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            nidx_q      <= {IDXW{1'b0}};
            lat_cnt_q   <= {LATW{1'b0}};
            act_ready_q <= 1'b0;
            w_rd_q      <= 1'b0;
            node_b_q    <= {VECW{1'b0}};
            node_bias_q <= {WORDW{1'b0}};
            res_valid_q <= 1'b0;
            res_data_q  <= {WORDW{1'b0}};
            res_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nidx_q      <= nidx_d;
            lat_cnt_q   <= lat_cnt_d;
            act_ready_q <= act_ready_d;
            w_rd_q      <= w_rd_d;
            node_b_q    <= node_b_d;
            node_bias_q <= node_bias_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
        end
    end

endmodule

// File: tb/tb_mnist_dlayer2_seq.sv
// Directed, table-driven bench for mnist_dlayer2_seq with a stub weight memory and stub node.
module tb_mnist_dlayer2_seq;
    import mnist_dlayer2_seq_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             act_valid;
    logic             act_ready;
    logic [31:0]      act_data;
    logic             w_rd;
    logic [3:0]       w_addr;
    logic [639:0]     w_rdata;
    logic [31:0]      b_rdata;
    logic [639:0]     node_a;
    logic [639:0]     node_b;
    logic [31:0]      node_bias;
    logic [31:0]      node_c;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [3:0]       res_idx;
    logic             res_last;

    int n_checks = 0;
    int n_errors = 0;
    int wrd_cnt  = 0;
    int acc_cnt  = 0;
    int exp_nidx = 0;
    logic        stub_fixed = 1'b0;
    logic [31:0] stub_val   = 32'd0;

    typedef struct {
        logic [31:0] base;
        logic        use_fixed;
        logic [31:0] fixed;
        int          stall_idx;
        logic        hold_valid;
    } vec_t;

    vec_t tbl [4];

    mnist_dlayer2_seq dut (
        .clk(clk), .rst_n(rst_n), .act_valid(act_valid), .act_ready(act_ready),
        .act_data(act_data), .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
        .b_rdata(b_rdata), .node_a(node_a), .node_b(node_b), .node_bias(node_bias),
        .node_c(node_c), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx), .res_last(res_last)
    );

    always #5 clk = ~clk;

    assign node_c = stub_fixed ? stub_val : (node_bias ^ node_a[31:0]);

    always @(posedge clk) begin
        if (w_rd) begin
            w_rdata <= {{19{32'h3F800000}}, 32'h3F800000 + {28'd0, w_addr}};
            b_rdata <= {28'd0, w_addr};
        end
    end

    task automatic chk(input string name, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            if (w_rd) begin
                chk("w_addr", {636'd0, w_addr}, 640'(exp_nidx));
                exp_nidx++;
                wrd_cnt++;
            end
            if (act_valid && act_ready) acc_cnt++;
        end
    end

    function automatic logic [31:0] exp_res(input logic [31:0] c);
`ifdef MNIST_DL2_RELU_EN
        return c[31] ? 32'd0 : c;
`else
        return c;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic send_words(input logic [31:0] base, input int count);
        int k = 0;
        int guard = 0;
        logic acc;
        act_valid = 1'b1;
        act_data  = base;
        while (k < count && guard < 400) begin
            acc = act_ready;
            tick();
            guard++;
            if (acc) begin
                k++;
                act_data = base + 32'(k);
            end
        end
        chk("send_words_done", 640'(k), 640'(count));
    endtask

    task automatic run_vector(input vec_t v);
        int          lat;
        logic [31:0] exp;
        logic [31:0] hold_d;
        logic [639:0] exp_a;
        stub_fixed = v.use_fixed;
        stub_val   = v.fixed;
        exp_nidx   = 0;
        wrd_cnt    = 0;
        acc_cnt    = 0;
        res_ready  = 1'b0;
        for (int k = 0; k < 20; k++) exp_a[32*k +: 32] = v.base + 32'(k);
        send_words(v.base, 20);
        if (!v.hold_valid) act_valid = 1'b0;
        for (int j = 0; j < 10; j++) begin
            wait_res(lat);
            if (j == 0) chk("first_latency", 640'(lat), 640'd6);
            exp = exp_res(v.use_fixed ? v.fixed : (32'(j) ^ v.base));
            chk("res_valid", {639'd0, res_valid}, 640'd1);
            chk("res_idx", {636'd0, res_idx}, 640'(j));
            chk("res_last", {639'd0, res_last}, {639'd0, (j == 9)});
            chk("res_data", {608'd0, res_data}, {608'd0, exp});
            chk("node_b", node_b, {{19{32'h3F800000}}, 32'h3F800000 + 32'(j)});
            chk("node_bias", {608'd0, node_bias}, 640'(j));
            chk("node_a", node_a, exp_a);
            chk("act_ready_busy", {639'd0, act_ready}, 640'd0);
            chk("w_rd_count", 640'(wrd_cnt), 640'(j + 1));
            if (j == v.stall_idx) begin
                hold_d = res_data;
                for (int c = 0; c < 7; c++) begin
                    tick();
                    chk("stall_valid", {639'd0, res_valid}, 640'd1);
                    chk("stall_data", {608'd0, res_data}, {608'd0, hold_d});
                    chk("stall_idx", {636'd0, res_idx}, 640'(j));
                    chk("stall_no_wrd", 640'(wrd_cnt), 640'(j + 1));
                end
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        chk("vec_w_rd_total", 640'(wrd_cnt), 640'd10);
        chk("vec_accepts", 640'(acc_cnt), 640'd20);
        chk("back_to_load", {639'd0, act_ready}, 640'd1);
        chk("res_valid_low", {639'd0, res_valid}, 640'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{base: 32'h3F800000, use_fixed: 1'b1, fixed: 32'h3F800000, stall_idx: -1, hold_valid: 1'b0};
        tbl[1] = '{base: 32'h00000100, use_fixed: 1'b0, fixed: 32'h00000000, stall_idx: 3,  hold_valid: 1'b1};
        tbl[2] = '{base: 32'hBF800000, use_fixed: 1'b1, fixed: 32'hBF800000, stall_idx: -1, hold_valid: 1'b1};
        tbl[3] = '{base: 32'hA5A50000, use_fixed: 1'b0, fixed: 32'h00000000, stall_idx: 9,  hold_valid: 1'b0};

        rst_n     = 1'b0;
        act_valid = 1'b0;
        act_data  = 32'd0;
        res_ready = 1'b0;
        #1;
        chk("rst_act_ready", {639'd0, act_ready}, 640'd0);
        chk("rst_w_rd", {639'd0, w_rd}, 640'd0);
        chk("rst_res", {603'd0, res_valid, res_last, res_idx, res_data}, 640'd0);
        chk("rst_node_a", node_a, 640'd0);
        chk("rst_node_b", node_b, 640'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 4; t++) run_vector(tbl[t]);
        act_valid = 1'b0;
        tick();

        // Reset mid-vector, then a fresh vector must use only its own words.
        send_words(32'hDEAD0000, 12);
        rst_n = 1'b0;
        #1;
        chk("midrst_act_ready", {639'd0, act_ready}, 640'd0);
        chk("midrst_res", {603'd0, res_valid, res_last, res_idx, res_data}, 640'd0);
        chk("midrst_node", node_a | node_b | {608'd0, node_bias}, 640'd0);
        chk("midrst_w_rd", {639'd0, w_rd}, 640'd0);
        act_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_vector('{base: 32'h12340000, use_fixed: 1'b0, fixed: 32'h00000000, stall_idx: -1, hold_valid: 1'b0});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
